// File: rtl/q2_i2c_pkg.sv
// Shared constants and types for the Q2 I2C master: opcodes, FSM/phase enums, status bits.
package q2_i2c_pkg;

  localparam logic [3:0] OP_START = 4'b0001;
  localparam logic [3:0] OP_STOP  = 4'b0010;
  localparam logic [3:0] OP_WRITE = 4'b0100;
  localparam logic [3:0] OP_READ  = 4'b1000;

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_STOP, ST_DATA, ST_ACK} state_t;
  typedef enum logic [1:0] {P0, P1, P2, P3} phase_t;

  localparam int STAT_BUSY = 11;
  localparam int STAT_NACK = 10;
  localparam int STAT_ERR  = 9;

endpackage

// File: rtl/q2_i2c_master_if.sv
// CPU command/status bus and I2C pin bundle for the Q2 I2C master.
interface q2_i2c_master_if;
  logic        wr;
  logic        rd;
  logic [11:0] din;
  logic [11:0] dout;
  logic        busy;
  logic        i2c_scl_out;
  logic        i2c_sda_out;
  logic        i2c_sda_in;
  logic        i2c_scl_in;

  modport master (
    input  wr, rd, din, i2c_sda_in, i2c_scl_in,
    output dout, busy, i2c_scl_out, i2c_sda_out
  );

  modport slave (
    output wr, rd, din, i2c_sda_in, i2c_scl_in,
    input  dout, busy, i2c_scl_out, i2c_sda_out
  );
endinterface

// File: rtl/q2_i2c_phase_gen.sv
// Quarter-bit timing: CLK_DIV clocks per phase, four phases per bus step.
// A stall holds the counter at its terminal count, stretching the current phase.
module q2_i2c_phase_gen
  import q2_i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   run,
  input  logic   stall,
  output phase_t phase,
  output logic   phase_done
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign phase_done = run && (cnt == TERM) && !stall;

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt   <= '0;
      phase <= P0;
    end else if (phase_done) begin
      cnt   <= '0;
      phase <= phase_t'(phase + 2'd1);
    end else if (cnt != TERM) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/q2_i2c_master.sv
// Q2 I2C master: one CPU command word per bus event (START/STOP/WRITE/READ).
// Optional slave clock stretching is enabled with `define I2C_CLOCK_STRETCH_EN.
module q2_i2c_master
  import q2_i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input logic             clk,
  input logic             rst,
  q2_i2c_master_if.master bus
);

  state_t      state, state_nx;
  phase_t      phase;
  logic        phase_done, step_done, stall, busy;
  logic        scl_q, sda_q, scl_o, sda_o;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg, rdata;
  logic        is_read, ack_bit, nack, err;
  logic [3:0]  op;
  logic        op_valid, accept, cmd_err;
  logic [11:0] status;

  assign op        = bus.din[11:8];
  assign busy      = (state != ST_IDLE);
  assign op_valid  = op inside {OP_START, OP_STOP, OP_WRITE, OP_READ};
  assign accept    = bus.wr && !busy && op_valid;
  assign cmd_err   = bus.wr && (busy || !op_valid);
  assign step_done = phase_done && (phase == P3);

`ifdef I2C_CLOCK_STRETCH_EN
  assign stall = scl_o && !bus.i2c_scl_in;
`else
  logic unused_scl_in;
  assign stall         = 1'b0;
  assign unused_scl_in = bus.i2c_scl_in;
`endif

  q2_i2c_phase_gen #(.CLK_DIV(CLK_DIV)) u_phase (
    .clk        (clk),
    .rst        (rst),
    .run        (busy),
    .stall      (stall),
    .phase      (phase),
    .phase_done (phase_done)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Pin levels are decoded from state/phase; scl_q/sda_q carry levels held between steps.
  always_comb begin
    state_nx = state;
    scl_o    = scl_q;
    sda_o    = sda_q;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (op)
            OP_START: state_nx = ST_START;
            OP_STOP:  state_nx = ST_STOP;
            default:  state_nx = ST_DATA;
          endcase
        end
      end
      ST_START: begin
        case (phase)
          P0:      sda_o = 1'b1;
          P1:      begin scl_o = 1'b1; sda_o = 1'b1; end
          P2:      begin scl_o = 1'b1; sda_o = 1'b0; end
          default: begin scl_o = 1'b0; sda_o = 1'b0; end
        endcase
        if (step_done) state_nx = ST_IDLE;
      end
      ST_STOP: begin
        case (phase)
          P0:      sda_o = 1'b0;
          P1:      begin scl_o = 1'b1; sda_o = 1'b0; end
          default: begin scl_o = 1'b1; sda_o = 1'b1; end
        endcase
        if (step_done) state_nx = ST_IDLE;
      end
      ST_DATA: begin
        scl_o = (phase == P1) || (phase == P2);
        sda_o = is_read ? 1'b1 : shreg[7];
        if (step_done && bit_cnt == 3'd7) state_nx = ST_ACK;
      end
      ST_ACK: begin
        scl_o = (phase == P1) || (phase == P2);
        sda_o = is_read ? ack_bit : 1'b1;
        if (step_done) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
      nack    <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
      bit_cnt <= '0;
    end else begin
      scl_q <= scl_o;
      sda_q <= sda_o;
      if (cmd_err)     err <= 1'b1;
      else if (bus.rd) err <= 1'b0;
      if (accept)                              bit_cnt <= '0;
      else if (state == ST_DATA && step_done) bit_cnt <= bit_cnt + 3'd1;
      if (state == ST_ACK && phase_done && phase == P2 && !is_read) nack <= bus.i2c_sda_in;
      if (state == ST_ACK && step_done && is_read) begin
        rdata <= shreg;
        nack  <= 1'b0;
      end
    end
  end

  // Write bits leave MSB first after p3; read bits enter at the end of p2.
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg   <= bus.din[7:0];
      is_read <= (op == OP_READ);
      ack_bit <= bus.din[0];
    end else if (state == ST_DATA && phase_done) begin
      if (is_read && phase == P2)       shreg <= {shreg[6:0], bus.i2c_sda_in};
      else if (!is_read && phase == P3) shreg <= {shreg[6:0], 1'b0};
    end
  end

  always_comb begin
    status            = '0;
    status[STAT_BUSY] = busy;
    status[STAT_NACK] = nack;
    status[STAT_ERR]  = err;
    status[7:0]       = rdata;
  end

  assign bus.dout        = status;
  assign bus.busy        = busy;
  assign bus.i2c_scl_out = scl_o;
  assign bus.i2c_sda_out = sda_o;

endmodule

// File: tb/tb_q2_i2c_master.sv
// Scoreboarded bench for q2_i2c_master: a bus decoder and slave model check each completed
// command and each status read against expectations derived from the command semantics.
module tb_q2_i2c_master;
  import q2_i2c_pkg::*;

  localparam int DIV = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  q2_i2c_master_if bus ();
  q2_i2c_master #(.CLK_DIV(DIV)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic slave_sda;
  logic stretch;
  assign bus.i2c_sda_in = bus.i2c_sda_out & slave_sda;
  assign bus.i2c_scl_in = bus.i2c_scl_out & ~stretch;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] data;
    logic       ack_drv;
    logic [7:0] sbyte;
    logic       exp_nack;
    logic [7:0] exp_rdata;
    int         exp_cycles;
  } cmd_t;

  typedef struct packed {
    logic [11:0] dout;
    logic        chk_bus;
    logic [1:0]  lines;
  } rd_t;

  cmd_t cmd_q[$];
  rd_t  rd_q[$];

  int vectors = 0;
  int miscompares = 0;

  logic       m_err, m_nack, m_abort, tmo_req, done_req;
  logic [7:0] m_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event not expected here", name);
  endtask

  // Monitor: decodes the bus, plays the slave, and scores completions and status reads.
  initial begin
    logic p_busy, p_scl, p_sda, ss, sp, sl, tmo_seen, done_seen;
    logic [8:0] b;
    int r, bl;
    cmd_t c;
    rd_t  rt;
    slave_sda = 1'b1;
    p_busy = 1'b0; p_scl = 1'b1; p_sda = 1'b1;
    ss = 1'b0; sp = 1'b0; b = '0; r = 0; bl = 0;
    tmo_seen = 1'b0; done_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        slave_sda = 1'b1;
      end else begin
        if (bus.busy && !p_busy) begin
          r = 0; ss = 1'b0; sp = 1'b0; b = '0; bl = 0;
        end
        if (bus.busy) bl++;
        if (p_scl && bus.i2c_scl_out) begin
          if (p_sda && !bus.i2c_sda_in) ss = 1'b1;
          if (!p_sda && bus.i2c_sda_in) sp = 1'b1;
        end
        if (!p_scl && bus.i2c_scl_out) begin
          if (r < 9) b = {b[7:0], bus.i2c_sda_in};
          r++;
        end
        if (!bus.busy) begin
          slave_sda = 1'b1;
        end else if (!bus.i2c_scl_out && cmd_q.size() > 0) begin
          sl = 1'b1;
          if (cmd_q[0].op == OP_READ && r < 8)       sl = cmd_q[0].sbyte[7-r];
          else if (cmd_q[0].op == OP_WRITE && r == 8) sl = cmd_q[0].ack_drv;
          slave_sda = sl;
        end

        if (p_busy && !bus.busy) begin
          if (cmd_q.size() == 0) begin
            flag("spurious_done");
          end else begin
            c = cmd_q.pop_front();
            if (m_abort) begin
              check("rst_dout", bus.dout, 0);
              check("rst_lines", {bus.i2c_scl_out, bus.i2c_sda_out}, 2'b11);
            end else begin
              check("busy_len", bl, c.exp_cycles);
              check("dout", bus.dout, {1'b0, c.exp_nack, m_err, 1'b0, c.exp_rdata});
              case (c.op)
                OP_START: check("start_cond", ss, 1);
                OP_STOP: begin
                  check("stop_cond", sp, 1);
                  check("stop_lines", {bus.i2c_scl_out, bus.i2c_sda_out}, 2'b11);
                end
                OP_WRITE: begin
                  check("wr_clocks", r, 9);
                  check("wr_byte", b[8:1], c.data);
                  check("wr_ack", b[0], c.ack_drv);
                end
                default: begin
                  check("rd_clocks", r, 9);
                  check("rd_byte", b[8:1], c.sbyte);
                  check("rd_ackbit", b[0], c.data[0]);
                end
              endcase
            end
          end
        end

        if (bus.rd) begin
          if (rd_q.size() == 0) begin
            flag("spurious_rd");
          end else begin
            rt = rd_q.pop_front();
            check("status", bus.dout, rt.dout);
            if (rt.chk_bus) check("idle_lines", {bus.i2c_scl_out, bus.i2c_sda_out}, rt.lines);
          end
        end

        if (tmo_req && !tmo_seen) begin
          flag("busy_timeout");
          tmo_seen = 1'b1;
        end
        if (done_req && !done_seen) begin
          check("cmd_queue_drained", cmd_q.size(), 0);
          check("rd_queue_drained", rd_q.size(), 0);
          done_seen = 1'b1;
        end
        p_busy = bus.busy;
      end
      p_scl = bus.i2c_scl_out;
      p_sda = bus.i2c_sda_in;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [7:0] data, input logic ack_drv,
                       input logic [7:0] sbyte, input int extra);
    cmd_t c;
    c.op = op; c.data = data; c.ack_drv = ack_drv; c.sbyte = sbyte;
    c.exp_cycles = ((op == OP_WRITE || op == OP_READ) ? 36 * DIV : 4 * DIV) + extra;
    if (op == OP_WRITE) m_nack = ack_drv;
    if (op == OP_READ) begin
      m_nack  = 1'b0;
      m_rdata = sbyte;
    end
    c.exp_nack = m_nack; c.exp_rdata = m_rdata;
    cmd_q.push_back(c);
    bus.din = {op, data};
    bus.wr  = 1'b1;
    tick();
    bus.wr  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 2000) begin
      tick();
      n++;
    end
    if (bus.busy) tmo_req = 1'b1;
    tick(2);
  endtask

  task automatic status_read(input logic chk_bus, input logic [1:0] lines);
    rd_t rt;
    rt.dout = {1'b0, m_nack, m_err, 1'b0, m_rdata};
    rt.chk_bus = chk_bus;
    rt.lines = lines;
    rd_q.push_back(rt);
    bus.rd = 1'b1;
    tick();
    bus.rd = 1'b0;
    m_err = 1'b0;
  endtask

  function automatic logic [3:0] bad_op();
    logic [3:0] o;
    o = 4'($urandom_range(0, 15));
    while ($countones(o) == 1) o = 4'($urandom_range(0, 15));
    return o;
  endfunction

  initial begin
    rd_t rt;
    int nk;
    bus.wr = 1'b0; bus.rd = 1'b0; bus.din = '0; stretch = 1'b0;
    m_err = 1'b0; m_nack = 1'b0; m_abort = 1'b0; m_rdata = '0;
    tmo_req = 1'b0; done_req = 1'b0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick();
    status_read(1'b1, 2'b11);

    issue(OP_START, 8'h00, 1'b0, 8'h00, 0); wait_idle();
    issue(OP_WRITE, 8'hA5, 1'b0, 8'h00, 0); wait_idle();
    issue(OP_READ,  8'h01, 1'b0, 8'h3C, 0); wait_idle();
    issue(OP_STOP,  8'h00, 1'b0, 8'h00, 0); wait_idle();
    status_read(1'b1, 2'b11);

    // Command while busy: ignored, err set, transfer undisturbed.
    issue(OP_START, 8'h00, 1'b0, 8'h00, 0); wait_idle();
    issue(OP_WRITE, 8'h5A, 1'b1, 8'h00, 0);
    tick(10);
    bus.din = 12'h400; bus.wr = 1'b1; m_err = 1'b1;
    tick();
    bus.wr = 1'b0;
    wait_idle();
    status_read(1'b0, 2'b00);
    status_read(1'b0, 2'b00);

    // Invalid opcode while idle, then the same together with a rd strobe.
    bus.din = {4'b0011, 8'h00}; bus.wr = 1'b1; m_err = 1'b1;
    tick();
    bus.wr = 1'b0;
    tick(4);
    status_read(1'b0, 2'b00);
    rt.dout = {1'b0, m_nack, m_err, 1'b0, m_rdata}; rt.chk_bus = 1'b0; rt.lines = 2'b00;
    rd_q.push_back(rt);
    bus.din = {bad_op(), 8'($urandom)}; bus.wr = 1'b1; bus.rd = 1'b1;
    tick();
    bus.wr = 1'b0; bus.rd = 1'b0; m_err = 1'b1;
    tick(2);
    status_read(1'b0, 2'b00);
    status_read(1'b0, 2'b00);

    for (int t = 0; t < 6; t++) begin
      issue(OP_START, 8'h00, 1'b0, 8'h00, 0); wait_idle();
      nk = int'($urandom_range(1, 3));
      for (int k = 0; k < nk; k++) begin
        if ($urandom_range(0, 1) == 1) issue(OP_WRITE, 8'($urandom), 1'($urandom), 8'h00, 0);
        else                           issue(OP_READ, 8'($urandom), 1'b0, 8'($urandom), 0);
        wait_idle();
      end
      if (t == 5 || $urandom_range(0, 1) == 1) begin
        issue(OP_STOP, 8'h00, 1'b0, 8'h00, 0); wait_idle();
        status_read(1'b1, 2'b11);
      end else begin
        status_read(1'b0, 2'b00);
      end
    end

`ifdef I2C_CLOCK_STRETCH_EN
    issue(OP_START, 8'h00, 1'b0, 8'h00, 0); wait_idle();
    issue(OP_WRITE, 8'h96, 1'b0, 8'h00, 0); wait_idle();
    issue(OP_START, 8'h00, 1'b0, 8'h00, 10);
    nk = 0;
    while (!bus.i2c_scl_out && nk < 100) begin
      tick();
      nk++;
    end
    tick();
    stretch = 1'b1;
    tick(10);
    stretch = 1'b0;
    wait_idle();
    issue(OP_STOP, 8'h00, 1'b0, 8'h00, 0); wait_idle();
`endif

    // Reset during the 4th data bit aborts immediately and releases the bus.
    issue(OP_START, 8'h00, 1'b0, 8'h00, 0); wait_idle();
    issue(OP_WRITE, 8'hC3, 1'b0, 8'h00, 0);
    tick(3 * 4 * DIV + DIV);
    m_abort = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(2);
    m_abort = 1'b0; m_err = 1'b0; m_nack = 1'b0; m_rdata = '0;
    status_read(1'b1, 2'b11);
    issue(OP_START, 8'h00, 1'b0, 8'h00, 0); wait_idle();
    issue(OP_STOP,  8'h00, 1'b0, 8'h00, 0); wait_idle();

    done_req = 1'b1;
    tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
